// File: rtl/mod_counter.sv
// Programmable modulo counter (free-run / one-shot) with registered tc, busy and done.
// Latency: outputs update one clk edge after the qualifying control; no backpressure, en simply gates counting.

module incrementor #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] sum
);
    // Natural wrap: the carry out of the top bit is dropped.
    assign sum = a + {{(N-1){1'b0}}, 1'b1};
endmodule

module mod_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] count_inc;

    incrementor #(.N(N)) u_inc (
        .a   (count),
        .sum (count_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            tc    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (stop) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start) begin
                // Restart from any state, including RUN and DONE.
                state <= S_RUN;
                count <= load_val;
                busy  <= 1'b1;
                done  <= 1'b0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (en) begin
                            if (count == limit) begin
                                tc <= 1'b1;
                                if (mode) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    count <= '0;
                                end
                            end else begin
                                count <= count_inc;
                            end
                        end
                    end
                    S_DONE: begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mod_counter.sv
// Randomized and directed bench for mod_counter, checked against a cycle-level behavioural model.

module tb_mod_counter;
    localparam int N   = 4;
    localparam int MOD = 2 ** N;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         en;
    logic         mode;
    logic [N-1:0] load_val;
    logic [N-1:0] limit;
    logic [N-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    int n_checks;
    int n_pass;

    int m_state;
    int m_cnt;
    int m_tc;
    int tc_seen;

    mod_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .mode     (mode),
        .load_val (load_val),
        .limit    (limit),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference: spec rules evaluated with plain integer arithmetic.
    task automatic model_edge();
        if (stop) begin
            m_state = M_IDLE;
            m_tc    = 0;
        end else if (start) begin
            m_state = M_RUN;
            m_cnt   = int'(load_val);
            m_tc    = 0;
        end else if (m_state == M_RUN && en) begin
            if (m_cnt == int'(limit)) begin
                m_tc = 1;
                if (mode) m_state = M_DONE;
                else      m_cnt   = 0;
            end else begin
                m_tc  = 0;
                m_cnt = (m_cnt + 1) % MOD;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".count"}, int'(count), m_cnt);
        chk({tag, ".tc"},    int'(tc),    m_tc);
        chk({tag, ".busy"},  int'(busy),  (m_state == M_RUN)  ? 1 : 0);
        chk({tag, ".done"},  int'(done),  (m_state == M_DONE) ? 1 : 0);
    endtask

    // Drives inputs at the falling edge, lets one rising edge pass, checks at the next falling edge.
    task automatic step(input string tag, input logic s, input logic p, input logic e,
                        input logic m, input int ld, input int lim);
        start    = s;
        stop     = p;
        en       = e;
        mode     = m;
        load_val = N'(ld);
        limit    = N'(lim);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (tc) tc_seen++;
        check_outputs(tag);
    endtask

    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, ".count"}, int'(count), 0);
        chk({tag, ".tc"},    int'(tc),    0);
        chk({tag, ".busy"},  int'(busy),  0);
        chk({tag, ".done"},  int'(done),  0);
        m_state = M_IDLE;
        m_cnt   = 0;
        m_tc    = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_state  = M_IDLE;
        m_cnt    = 0;
        m_tc     = 0;
        tc_seen  = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        en       = 1'b0;
        mode     = 1'b0;
        load_val = '0;
        limit    = '0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Free-run 0..9: two tc pulses in 25 enabled cycles.
        step("fr_start", 1, 0, 0, 0, 0, 9);
        tc_seen = 0;
        for (int i = 0; i < 25; i++) step("fr", 0, 0, 1, 0, 0, 9);
        chk("fr_tc_pulses", tc_seen, 2);
        chk("fr_end_count", int'(count), 5);

        // Reset mid-count at 5.
        mid_reset("rst_mid");
        step("rst_idle", 0, 0, 1, 0, 0, 9);

        // One-shot 3..7, hold, then restart.
        step("os_start", 1, 0, 0, 1, 3, 7);
        tc_seen = 0;
        for (int i = 0; i < 8; i++) step("os", 0, 0, 1, 1, 3, 7);
        chk("os_tc_pulses", tc_seen, 1);
        chk("os_hold", int'(count), 7);
        step("os_restart", 1, 0, 1, 1, 3, 7);
        chk("os_restart_count", int'(count), 3);

        // Wrap past all-ones: 14,15,0,1,2,0.
        step("wr_start", 1, 0, 0, 0, 14, 2);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) step("wr", 0, 0, 1, 0, 14, 2);
        chk("wr_tc_pulses", tc_seen, 1);
        chk("wr_end_count", int'(count), 0);

        // Priority: stop over start over en.
        step("pr_start", 1, 0, 0, 0, 0, 9);
        for (int i = 0; i < 4; i++) step("pr_cnt", 0, 0, 1, 0, 0, 9);
        step("pr_all", 1, 1, 1, 0, 0, 9);
        chk("pr_hold4", int'(count), 4);
        step("pr_start_en", 1, 0, 1, 0, 1, 9);
        chk("pr_no_inc", int'(count), 1);

        // en gating then limit 0.
        step("eg_en1", 0, 0, 1, 0, 1, 6);
        step("eg_en0", 0, 0, 0, 0, 1, 6);
        step("eg_en1b", 0, 0, 1, 0, 1, 6);
        chk("eg_count", int'(count), 3);
        step("l0_start", 1, 0, 0, 0, 0, 0);
        tc_seen = 0;
        for (int i = 0; i < 4; i++) step("l0", 0, 0, 1, 0, 0, 0);
        chk("l0_tc_pulses", tc_seen, 4);
        step("l0os_start", 1, 0, 0, 1, 0, 0);
        step("l0os", 0, 0, 1, 1, 0, 0);
        chk("l0os_done", int'(done), 1);

        // Randomized phase: rare start/stop/reset, live limit changes.
        begin
            int lim_r;
            lim_r = int'($urandom_range(0, MOD - 1));
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 19) == 0) lim_r = int'($urandom_range(0, MOD - 1));
                if ($urandom_range(0, 149) == 0) mid_reset("rnd_rst");
                step("rnd",
                     logic'($urandom_range(0, 14) == 0),
                     logic'($urandom_range(0, 29) == 0),
                     logic'($urandom_range(0, 3) != 0),
                     logic'($urandom_range(0, 3) == 0),
                     int'($urandom_range(0, MOD - 1)),
                     lim_r);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Registered N-bit programmable modulo counter built around the combinational incrementor.
- Holds the count state and feeds it back through an incrementor instance.
- Adds start/stop control, a live terminal limit, free-run and one-shot modes, and a terminal-count pulse.
- Sits directly downstream of the incrementor: it consumes the incrementor's output as the next-state value.

Parameters:
N, 4, counter width in bits; legal range 4 to 8. The incrementor instance uses the same N.

Ports:
clk  input  1  single system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  pulse: load load_val and enter RUN.
stop  input  1  pulse: abort to IDLE.
en  input  1  count enable, sampled in RUN only.
mode  input  1  0 = free-run (wrap at limit), 1 = one-shot (halt at limit); sampled every cycle.
load_val  input  N  start value, sampled on start.
limit  input  N  terminal value, sampled live every cycle.
count  output  N  current count register.
tc  output  1  registered one-cycle terminal-count pulse.
busy  output  1  high while in RUN.
done  output  1  high while in DONE (one-shot completed).

Behaviour:
- Reset (asynchronous, immediate, including mid-count):
  - count=0, tc=0, busy=0, done=0, state=IDLE.
- All other updates occur on the rising edge of clk.
- States: IDLE, RUN, DONE (2-bit encoded). busy and done are registered and decoded from the state: busy=(RUN), done=(DONE).
- Control priority each edge: stop > start > en.
- stop in any state:
  - next state IDLE; count holds its value; tc=0.
- start (with stop=0) in any state, including RUN and DONE:
  - count <= load_val; next state RUN; tc=0.
  - A start while in RUN is a restart, not an error.
- IDLE with no start: count holds; tc=0.
- RUN with en=0: count holds; tc=0.
- RUN with en=1 and count != limit:
  - count <= incrementor(count), i.e. count+1 mod 2^N; tc=0.
- RUN with en=1 and count == limit:
  - tc <= 1 for exactly one cycle.
  - mode=0: count <= 0; remain in RUN.
  - mode=1: count holds at limit; next state DONE.
- DONE:
  - count holds; done=1 until start or stop; en is ignored; tc=0.
- Latency:
  - count changes one edge after a qualifying en.
  - tc is high during the cycle immediately after the terminal edge, when count shows 0 (mode 0) or limit (mode 1).
- Period in free-run with load_val=0: limit+1 enabled cycles between tc pulses.
- Wrap-around rules:
  - If load_val > limit, counting proceeds through 2^N-1 to 0 (incrementor natural wrap, carry-out discarded) and continues until count==limit.
  - Never saturate; never generate tc at the 2^N-1 wrap unless limit==2^N-1.
- limit==0:
  - mode 0: tc on every enabled cycle, count stays 0.
  - mode 1: DONE after one enabled cycle.
- limit changed mid-count: the new value takes effect immediately. If the count has already passed the new limit, it runs to 2^N-1, wraps and then reaches the new limit.
- start and en in the same cycle: start wins; no increment that cycle.
- Counting arithmetic must use the incrementor instance. Do not use an inline +1.

Test Plan:
- Reset: assert rst mid-count at count=5 (N=4) -> same cycle count=0, tc=0, busy=0, done=0; state IDLE after release.
- Free-run: load_val=0, limit=9, mode=0, start then en=1 for 25 cycles -> count sequence 0..9,0..9,0..4; tc high exactly on the 2 cycles where count returns to 0; busy=1 throughout.
- One-shot: load_val=3, limit=7, mode=1, en=1 -> count 3,4,5,6,7; done=1 with count held at 7 thereafter; tc one pulse; start again -> count=3, busy=1, done=0.
- Wrap past all-ones: N=4, load_val=14, limit=2, mode=0, en=1 -> 14,15,0,1,2,0; tc only after the 2->0 edge.
- Priority: stop, start and en all high while in RUN at count=4 -> IDLE, count stays 4, busy=0; then start+en together with load_val=1 -> count=1, no increment that cycle.
- en gating and limit=0: in RUN with en toggling 1,0,1 and limit=6 -> count advances only on en=1 cycles; then with limit=0, mode=0, en=1 -> count stays 0 and tc is high every cycle.
